// File: rtl/led_arb_pkg.sv
// ---------------------------------------------------------------------------
// led_arb_pkg
// Shared types and helpers for the LED bank arbiter.
//   arb_state_t : FSM state encoding (IDLE, OWN, RELEASE)
//   N_REQ       : number of requesters sharing the LED bank
//   LED_W       : width of the LED bank / requester patterns
//   LED_IDLE    : bank value shown while nobody owns it (LED5 lit)
//   idx_to_oh   : requester index -> one-hot grant vector
//   rr_next     : next index in round-robin order (mod N_REQ)
//   rr_pick     : first requesting index after 'last' in round-robin order
// ---------------------------------------------------------------------------
package led_arb_pkg;

  localparam int N_REQ = 3;
  localparam int LED_W = 5;

  localparam logic [LED_W-1:0] LED_IDLE = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_to_oh(input logic [1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    logic [1:0] nxt;
    nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    return nxt;
  endfunction

  // Search order is last+1, last+2, last; the previous owner is considered
  // only after every other requester, which is what makes a release fair.
  function automatic logic [1:0] rr_pick(input logic [1:0]       last,
                                         input logic [N_REQ-1:0] req);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] pick;
    c1 = rr_next(last);
    c2 = rr_next(c1);
    if ((req & idx_to_oh(c1)) != '0)      pick = c1;
    else if ((req & idx_to_oh(c2)) != '0) pick = c2;
    else                                  pick = last;
    return pick;
  endfunction

endpackage

// File: rtl/led_arbiter_tick_div.sv
// ---------------------------------------------------------------------------
// led_tick_div
// Free-running scheduling-tick divider. Counts 0..TICK_DIV-1 and raises
// 'tick' for the single cycle in which the count sits at TICK_DIV-1; the
// count wraps to 0 on that same edge. While 'en' is low the count is held
// at 0 and no tick is produced.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (count -> 0)
//   en    : count enable
//   tick  : one-cycle pulse every TICK_DIV enabled cycles
// ---------------------------------------------------------------------------
module led_tick_div #(
  parameter int TICK_DIV = 1200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/led_arbiter.sv
// ---------------------------------------------------------------------------
// led_arbiter
// Round-robin arbiter giving one of three requesters ownership of a 5-LED
// bank. An owner keeps the bank for at least HOLD_TICKS scheduling ticks and
// loses it after MAX_TICKS ticks if someone else is waiting.
//
// Request/grant protocol: req[i] is a level held by requester i for as long
// as it wants the bank. grant is registered and one-hot; grant[i] rises the
// cycle after the arbiter accepts req[i] and stays high until the grant
// ends, at which point grant drops and done pulses for exactly one cycle.
// A requester must keep req high to keep its pattern live; dropping req
// freezes the displayed pattern and, once the minimum hold has elapsed,
// ends the grant.
//
// Optional feature (macro LED_ARB_STARTUP_EN): a startup blanking counter
// of STARTUP_CYCLES cycles after reset, during which no grant is issued and
// the tick divider is held at 0. Without the macro arbitration starts on the
// first clock after reset release.
//
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   req[2:0]       : request level per requester
//   pat0/pat1/pat2 : LED pattern of requester i, bit0 -> LED1 .. bit4 -> LED5
//   grant[2:0]     : one-hot ownership, registered
//   done           : one-cycle pulse when a grant ends
//   LED1..LED5     : LED bank, registered
//   idle           : high while no requester owns the bank
// ---------------------------------------------------------------------------
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int TICK_DIV       = 1200000,
  parameter int HOLD_TICKS     = 4,
  parameter int MAX_TICKS      = 16,
  parameter int STARTUP_CYCLES = 12000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [LED_W-1:0] pat0,
  input  logic [LED_W-1:0] pat1,
  input  logic [LED_W-1:0] pat2,
  output logic [N_REQ-1:0] grant,
  output logic             done,
  output logic             LED1,
  output logic             LED2,
  output logic             LED3,
  output logic             LED4,
  output logic             LED5,
  output logic             idle
);

  // Parameter sanity checks, evaluated at elaboration.
  if (TICK_DIV < 2) begin : g_chk_div
    $error("led_arbiter: TICK_DIV must be >= 2");
  end
  if (HOLD_TICKS < 1) begin : g_chk_hold
    $error("led_arbiter: HOLD_TICKS must be >= 1");
  end
  if (MAX_TICKS < HOLD_TICKS) begin : g_chk_max
    $error("led_arbiter: MAX_TICKS must be >= HOLD_TICKS");
  end
  if (STARTUP_CYCLES < 1) begin : g_chk_start
    $error("led_arbiter: STARTUP_CYCLES must be >= 1");
  end

  localparam int HW = $clog2(MAX_TICKS + 1);
  localparam logic [HW-1:0] HOLD_V = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] MAX_V  = HW'(MAX_TICKS);

  arb_state_t       state;
  logic [1:0]       owner;
  logic [1:0]       last_owner;
  logic [HW-1:0]    hold_cnt;
  logic [N_REQ-1:0] grant_q;
  logic             done_q;
  logic [LED_W-1:0] led_q;
  logic             idle_q;

  logic             run;
  logic             tick;
  logic [1:0]       sel;
  logic [N_REQ-1:0] owner_oh;
  logic             own_req;
  logic             other_req;
  logic             rel_cond;
  logic [LED_W-1:0] pat_sel;

  // -------------------------------------------------------------------------
  // Arbitration enable: optional startup blanking
  // -------------------------------------------------------------------------
`ifdef LED_ARB_STARTUP_EN
  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYCLES);

  logic [SW-1:0] start_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= '0;
    end else if (start_cnt != START_LAST) begin
      start_cnt <= start_cnt + SW'(1);
    end
  end

  assign run = (start_cnt == START_LAST);
`else
  assign run = 1'b1;
`endif

  led_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .tick  (tick)
  );

  // -------------------------------------------------------------------------
  // Selection and release conditions
  // -------------------------------------------------------------------------
  assign sel       = rr_pick(last_owner, req);
  assign owner_oh  = idx_to_oh(owner);
  assign own_req   = |(req & owner_oh);
  assign other_req = |(req & ~owner_oh);

  // Normal release once the minimum hold is met and the owner has let go;
  // fairness revoke once the maximum is reached and someone else waits.
  assign rel_cond = ((hold_cnt >= HOLD_V) && !own_req) ||
                    ((hold_cnt == MAX_V) && other_req);

  always_comb begin
    pat_sel = pat2;
    case (owner)
      2'd0:    pat_sel = pat0;
      2'd1:    pat_sel = pat1;
      default: pat_sel = pat2;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      hold_cnt   <= '0;
      grant_q    <= '0;
      done_q     <= 1'b0;
      led_q      <= LED_IDLE;
      idle_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          grant_q <= '0;
          led_q   <= LED_IDLE;
          idle_q  <= 1'b1;
          if (run && (req != '0)) begin
            state    <= ST_OWN;
            owner    <= sel;
            grant_q  <= idx_to_oh(sel);
            hold_cnt <= '0;
            // The owner's pattern appears one cycle after the grant, so the
            // bank is dark for the first owned cycle.
            led_q    <= '0;
            idle_q   <= 1'b0;
          end
        end

        ST_OWN: begin
          if (tick && (hold_cnt != MAX_V)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
          // Pattern follows the owner only while it is requesting; otherwise
          // the last sampled pattern stays on the bank.
          if (own_req) begin
            led_q <= pat_sel;
          end
          if (rel_cond) begin
            state   <= ST_RELEASE;
            grant_q <= '0;
            done_q  <= 1'b1;
            led_q   <= '0;
            idle_q  <= 1'b1;
          end
        end

        ST_RELEASE: begin
          state      <= ST_IDLE;
          last_owner <= owner;
          led_q      <= LED_IDLE;
          idle_q     <= 1'b1;
        end

        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          led_q   <= LED_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign idle  = idle_q;
  assign LED1  = led_q[0];
  assign LED2  = led_q[1];
  assign LED3  = led_q[2];
  assign LED4  = led_q[3];
  assign LED5  = led_q[4];

endmodule

// File: tb/tb_led_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_arbiter
// Directed bench for led_arbiter with TICK_DIV=4, HOLD_TICKS=2, MAX_TICKS=4.
// The tick divider is free-running from reset, so ticks land on clock edges
// whose number since reset release is a multiple of TICK_DIV; expected grant
// lengths are derived from that grid. Expected grant vectors are queued when
// requests are driven and popped when a grant appears.
// ---------------------------------------------------------------------------
module tb_led_arbiter;

  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 2;
  localparam int MAX_TICKS  = 4;
  localparam int START_CYC  = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] req  = 3'b000;
  logic [4:0] pat0 = 5'h00;
  logic [4:0] pat1 = 5'h00;
  logic [4:0] pat2 = 5'h00;
  logic [2:0] grant;
  logic       done;
  logic       LED1, LED2, LED3, LED4, LED5;
  logic       idle;
  logic [4:0] leds;

  assign leds = {LED5, LED4, LED3, LED2, LED1};

  led_arbiter #(
    .TICK_DIV       (TICK_DIV),
    .HOLD_TICKS     (HOLD_TICKS),
    .MAX_TICKS      (MAX_TICKS),
    .STARTUP_CYCLES (START_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .pat0  (pat0),
    .pat1  (pat1),
    .pat2  (pat2),
    .grant (grant),
    .done  (done),
    .LED1  (LED1),
    .LED2  (LED2),
    .LED3  (LED3),
    .LED4  (LED4),
    .LED5  (LED5),
    .idle  (idle)
  );

  // edge counter since reset release (edge 1 = first rising edge after)
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // scoreboard
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int next_tick(input int e);
    return (e / TICK_DIV + 1) * TICK_DIV;
  endfunction

  // Wait for a grant to appear; compare it against the queued expectation.
  task automatic wait_grant(input string tag, input int budget, output int e0);
    int         n;
    logic [2:0] exp;
    n = 0;
    do begin
      step();
      n++;
      check({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
    end while ((grant == 3'b000) && (n < budget));
    e0 = cyc;
    if (grant == 3'b000) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s_timeout: grant 000 after %0d cycles, required nonzero", tag, n);
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s_unexpected: grant %b observed, required none queued", tag, grant);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_grant"}, 32'(grant), 32'(exp));
    end
  endtask

  // Wait for the grant to end; check the RELEASE cycle and the IDLE after it.
  task automatic wait_release(input string tag, input int budget, output int r);
    int n;
    n = 0;
    while ((grant != 3'b000) && (n < budget)) begin
      step();
      n++;
      check({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
    end
    r = cyc;
    if (grant != 3'b000) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s_timeout: grant %b after %0d cycles, required 000", tag, grant, n);
    end else begin
      check({tag, "_done"},     32'(done), 32'd1);
      check({tag, "_rel_leds"}, 32'(leds), 32'h00);
      check({tag, "_rel_idle"}, 32'(idle), 32'd1);
      step();
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_leds"}, 32'(leds), 32'h10);
      check({tag, "_idle_idle"}, 32'(idle), 32'd1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d, e0, e1, r, t1, prev_r;

    pat0 = 5'h0A;
    pat1 = 5'h1F;
    pat2 = 5'h15;

`ifdef LED_ARB_STARTUP_EN
    // ---- startup blanking: req=010 from reset ----
    req   = 3'b010;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 1; i <= START_CYC; i++) begin
      step();
      check("startup_blank_grant", 32'(grant), 32'd0);
      check("startup_blank_leds",  32'(leds),  32'h10);
    end
    step();
    check("startup_first_cycle", 32'(cyc),   32'(START_CYC + 1));
    check("startup_first_grant", 32'(grant), 32'b010);
`else
    // ---- reset state ----
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_leds",  32'(leds),  32'h10);
    check("rst_idle",  32'(idle),  32'd1);
    rst_n = 1'b1;

    // ---- no requests: stays idle ----
    repeat (3) step();
    check("noreq_grant", 32'(grant), 32'd0);
    check("noreq_leds",  32'(leds),  32'h10);
    check("noreq_idle",  32'(idle),  32'd1);

    // ---- held request, pattern follows the owner ----
    req = 3'b001;
    d   = cyc;
    exp_q.push_back(3'b001);
    wait_grant("held", 4, e0);
    check("held_latency", 32'(e0), 32'(d + 1));
    check("held_idle",    32'(idle), 32'd0);
    step();
    check("held_leds", 32'(leds), 32'h0A);
    pat0 = 5'h13;
    step();
    check("held_leds_follow", 32'(leds), 32'h13);
    repeat (30) step();
    check("held_long_grant", 32'(grant), 32'b001);
    check("held_long_leds",  32'(leds),  32'h13);
    req = 3'b000;
    d   = cyc;
    wait_release("held_rel", 4, r);
    check("held_rel_edge", 32'(r), 32'(d + 1));

    // ---- 1-cycle pulse: held for HOLD_TICKS ticks ----
    pat0 = 5'h0A;
    req  = 3'b001;
    exp_q.push_back(3'b001);
    wait_grant("pulse", 4, e0);
    req = 3'b000;
    check("pulse_leds_dark", 32'(leds), 32'h00);
    wait_release("pulse_rel", 20, r);
    check("pulse_rel_edge", 32'(r),
          32'(next_tick(e0) + TICK_DIV * (HOLD_TICKS - 1) + 1));

    // ---- early drop keeps last latched pattern until the hold ends ----
    req = 3'b001;
    exp_q.push_back(3'b001);
    wait_grant("early", 4, e0);
    step();
    check("early_leds", 32'(leds), 32'h0A);
    req  = 3'b000;
    pat0 = 5'h1F;
    step();
    check("early_leds_frozen", 32'(leds),  32'h0A);
    check("early_grant_kept",  32'(grant), 32'b001);
    wait_release("early_rel", 20, r);
    check("early_rel_edge", 32'(r),
          32'(next_tick(e0) + TICK_DIV * (HOLD_TICKS - 1) + 1));

    // ---- reset mid-OWN ----
    req = 3'b010;
    exp_q.push_back(3'b010);
    wait_grant("midrst", 4, e0);
    repeat (3) step();
    check("midrst_owned", 32'(grant), 32'b010);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_done",  32'(done),  32'd0);
    check("midrst_led5",  32'(LED5),  32'd1);
    check("midrst_idle",  32'(idle),  32'd1);
    step();
    check("midrst_done_later", 32'(done), 32'd0);

    // ---- all requesting from reset: round robin with fairness revoke ----
    req = 3'b111;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    rst_n  = 1'b1;
    prev_r = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("rr", 40, e0);
      if (k == 0) check("rr_first_entry", 32'(e0), 32'd1);
      else        check("rr_entry_gap",   32'(e0), 32'(prev_r + 2));
      if (k < 3) begin
        wait_release("rr_rel", 40, r);
        check("rr_revoke_edge", 32'(r),
              32'(next_tick(e0) + TICK_DIV * (MAX_TICKS - 1) + 1));
        prev_r = r;
      end else begin
        req = 3'b000;
        wait_release("rr_last_rel", 40, r);
        check("rr_last_rel_edge", 32'(r),
              32'(next_tick(e0) + TICK_DIV * (HOLD_TICKS - 1) + 1));
      end
    end

    // ---- contender arrives at hold_cnt=1: revoke exactly at MAX_TICKS ----
    req = 3'b001;
    exp_q.push_back(3'b001);
    wait_grant("late", 4, e0);
    t1 = next_tick(e0);
    for (int n = 0; (cyc < t1) && (n < 20); n++) step();
    check("late_at_tick1", 32'(cyc), 32'(t1));
    req = 3'b011;
    exp_q.push_back(3'b010);
    wait_release("late_rel", 40, r);
    check("late_revoke_edge", 32'(r), 32'(t1 + TICK_DIV * (MAX_TICKS - 1) + 1));
    wait_grant("late_next", 4, e1);
    check("late_next_entry", 32'(e1), 32'(r + 2));
    step();
    check("late_next_leds", 32'(leds), 32'h1F);
    req = 3'b000;
    wait_release("late_next_rel", 40, r);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
